// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 matrix keypad scanner.
// Key codes are row*4 + col.
package keypad_pkg;

    localparam int KEY_W = 4;
    localparam int ROWS  = 4;
    localparam int COLS  = 4;

    typedef enum logic [2:0] {
        SCAN,
        PRESS_DEB,
        REPORT,
        HOLD,
        REL_DEB
    } state_t;

    // Codes of the digit keys 0-7 (rows 0 and 1).
    localparam logic [7:0][KEY_W-1:0] DIGIT_CODE = {
        4'd7, 4'd6, 4'd5, 4'd4,
        4'd3, 4'd2, 4'd1, 4'd0
    };

    function automatic logic [KEY_W-1:0] key_code(
        input logic [1:0] r,
        input logic [1:0] c
    );
        return {r, c};
    endfunction

    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/keypad_sync.sv
// Two-flop synchroniser for asynchronous inputs, resets to all ones
// so an idle pulled-up bus looks released out of reset.
module keypad_sync #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '1;
            q    <= '1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 active-low keypad scanner with press/release debounce.
// Optional auto-repeat while held: define KEYPAD_AUTOREPEAT_EN.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV        = 1000,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [COLS-1:0]  col_n,
    output logic [ROWS-1:0]  row_n,
    output logic [KEY_W-1:0] key_value,
    output logic             key_valid,
    output logic             key_held
);

    if (SCAN_DIV < 4 || DEBOUNCE_CYCLES < 1 ||
        REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_cfg
        $error("keypad_scanner: illegal parameter value");
    end

    localparam int DW = cnt_w(SCAN_DIV);
    localparam int BW = cnt_w(DEBOUNCE_CYCLES);
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [BW-1:0] DEB_LAST   = BW'(DEBOUNCE_CYCLES - 1);

    state_t         state, state_d;
    logic [1:0]     row, row_d;
    logic [1:0]     lat_col, lat_col_d;
    logic [DW-1:0]  dwell, dwell_d;
    logic [BW-1:0]  deb, deb_d;
    logic [KEY_W-1:0] value_d;

    logic [COLS-1:0] cs;
    logic [1:0]      low_col;
    logic            any_low;
    logic            col_up;
    logic            rpt_fire;

    keypad_sync #(
        .W(COLS)
    ) u_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (col_n),
        .q    (cs)
    );

    // Lowest-numbered pressed column wins.
    always_comb begin
        low_col = 2'd0;
        for (int i = COLS - 1; i >= 0; i--) begin
            if (!cs[i]) low_col = i[1:0];
        end
    end

    assign any_low = ~&cs;
    assign col_up  = cs[lat_col];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= SCAN;
            row       <= 2'd0;
            lat_col   <= 2'd0;
            dwell     <= '0;
            deb       <= '0;
            key_value <= DIGIT_CODE[0];
        end else begin
            state     <= state_d;
            row       <= row_d;
            lat_col   <= lat_col_d;
            dwell     <= dwell_d;
            deb       <= deb_d;
            key_value <= value_d;
        end
    end

    always_comb begin
        state_d   = state;
        row_d     = row;
        lat_col_d = lat_col;
        dwell_d   = dwell;
        deb_d     = deb;
        value_d   = key_value;
        unique case (state)
            SCAN: begin
                if (dwell == DWELL_LAST) begin
                    dwell_d = '0;
                    if (any_low) begin
                        lat_col_d = low_col;
                        deb_d     = '0;
                        state_d   = PRESS_DEB;
                    end else begin
                        row_d = row + 2'd1;
                    end
                end else begin
                    dwell_d = dwell + 1'b1;
                end
            end
            PRESS_DEB: begin
                if (col_up) begin
                    deb_d   = '0;
                    dwell_d = '0;
                    state_d = SCAN;
                end else if (deb == DEB_LAST) begin
                    deb_d   = '0;
                    value_d = key_code(row, lat_col);
                    state_d = REPORT;
                end else begin
                    deb_d = deb + 1'b1;
                end
            end
            REPORT: begin
                state_d = HOLD;
            end
            HOLD: begin
                if (col_up) begin
                    deb_d   = '0;
                    state_d = REL_DEB;
                end
            end
            REL_DEB: begin
                if (!col_up) begin
                    deb_d   = '0;
                    state_d = HOLD;
                end else if (deb == DEB_LAST) begin
                    deb_d   = '0;
                    dwell_d = '0;
                    row_d   = row + 2'd1;
                    state_d = SCAN;
                end else begin
                    deb_d = deb + 1'b1;
                end
            end
            default: begin
                state_d = SCAN;
            end
        endcase
    end

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ?
                          REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW = cnt_w(RMAX);

    logic [RW-1:0] rpt;
    logic [RW-1:0] rpt_last;
    logic          rpt_armed;

    // First repeat waits the long delay, later ones the short period.
    assign rpt_last = rpt_armed ? RW'(REPEAT_PERIOD - 1)
                                : RW'(REPEAT_DELAY - 1);
    assign rpt_fire = (state == HOLD) && (rpt == rpt_last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rpt       <= '0;
            rpt_armed <= 1'b0;
        end else if (state != HOLD) begin
            rpt       <= '0;
            rpt_armed <= 1'b0;
        end else if (rpt_fire) begin
            rpt       <= '0;
            rpt_armed <= 1'b1;
        end else begin
            rpt <= rpt + 1'b1;
        end
    end
`else
    assign rpt_fire = 1'b0;
`endif

    assign row_n     = ~(4'b0001 << row);
    assign key_valid = (state == REPORT) || rpt_fire;
    assign key_held  = (state == HOLD) || (state == REL_DEB);

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner with a physical keypad model.
// Define KEYPAD_AUTOREPEAT_EN to also expect auto-repeat pulses.
module tb_keypad_scanner;

    localparam int SD = 4;
    localparam int DC = 8;
    localparam int RD = 40;
    localparam int RP = 20;
`ifdef KEYPAD_AUTOREPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] col_n;
    logic [3:0] row_n;
    logic [3:0] key_value;
    logic       key_valid;
    logic       key_held;
    logic [15:0] keys = '0;

    int cyc = 0;
    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic [3:0] val;
        int         lo;
        int         hi;
    } exp_t;

    exp_t exp_q[$];

    keypad_scanner #(
        .SCAN_DIV       (SD),
        .DEBOUNCE_CYCLES(DC),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .col_n    (col_n),
        .row_n    (row_n),
        .key_value(key_value),
        .key_valid(key_valid),
        .key_held (key_held)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Pressed key shorts its column to its row when that row is driven low.
    always_comb begin
        col_n = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys[r*4+c] && !row_n[r]) col_n[c] = 1'b0;
            end
        end
    end

    task automatic check(input string name, input logic [3:0] act,
                         input logic [3:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %b, required %b (cyc %0d)",
                     name, act, req, cyc);
        end
    endtask

    task automatic push(input logic [3:0] v, input int lo, input int hi);
        exp_t e;
        e.val = v;
        e.lo  = lo;
        e.hi  = hi;
        exp_q.push_back(e);
    endtask

    // Repeat pulses expected while HOLD lasts (key released at slot n).
    task automatic push_repeats(input logic [3:0] v, input int t,
                                input int n);
        if (AR) begin
            for (int p = t + RD; p <= n + 2; p += RP) push(v, p, p);
        end
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic wait_row(input int r, output int slot);
        logic [3:0] want;
        logic [3:0] prev;
        want = ~(4'b0001 << r);
        prev = row_n;
        slot = -1;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (row_n == want && prev != want) begin
                slot = cyc;
                break;
            end
            prev = row_n;
        end
        vectors++;
        if (slot < 0) begin
            miscompares++;
            $display("FAIL wait_row: row %0d never driven, row_n=%b",
                     r, row_n);
        end
    endtask

    // Monitor: every key_valid pulse must match the next expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && key_valid) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL pulse: got key %0d at cyc %0d, required none",
                         key_value, cyc);
            end else begin
                e = exp_q.pop_front();
                if (key_value !== e.val || cyc < e.lo || cyc > e.hi) begin
                    miscompares++;
                    $display("FAIL pulse: got key %0d at cyc %0d, required %0d in [%0d,%0d]",
                             key_value, cyc, e.val, e.lo, e.hi);
                end
            end
        end
    end

    initial begin
        int s0;
        int r;
        int n;
        int b;
        int t;

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_row_n", row_n, 4'b1110);
        check("rst_value", key_value, 4'd0);
        check("rst_valid", {3'b000, key_valid}, 4'd0);
        check("rst_held", {3'b000, key_held}, 4'd0);

        // Idle scan: each row held SD cycles, wrapping 3 -> 0.
        rst_n = 1'b1;
        s0 = cyc;
        for (int k = 0; k < 64; k++) begin
            if (k > 0) @(negedge clk);
            check("idle_row_n", row_n, ~(4'b0001 << ((k / 4) % 4)));
        end

        // Clean press of row 2 col 1, pressed as row 2 starts its dwell.
        wait_row(2, r);
        keys[9] = 1'b1;
        t = r + 12;
        n = r + 100;
        push(4'd9, t, t);
        push_repeats(4'd9, t, n);
        wait_until(r + 50);
        check("press_held", {3'b000, key_held}, 4'd1);
        wait_until(n);
        keys[9] = 1'b0;
        wait_until(n + 8);
        check("rel_held_8", {3'b000, key_held}, 4'd1);
        wait_until(n + 12);
        check("rel_held_off", {3'b000, key_held}, 4'd0);
        check("rel_next_row", row_n, 4'b0111);

        // Press bounce on row 3 col 2: low 3, high 1, six times.
        for (int i = 0; i < 6; i++) begin
            keys[14] = 1'b1;
            repeat (3) @(negedge clk);
            keys[14] = 1'b0;
            @(negedge clk);
        end
        keys[14] = 1'b1;
        b = cyc;
        push(4'd14, b + 11, b + 34);
        wait_until(b + 40);
        keys[14] = 1'b0;
        wait_until(b + 60);
        check("bounce_released", {3'b000, key_held}, 4'd0);

        // Two keys on row 1: lowest column wins, single pulse.
        wait_row(1, r);
        keys[4] = 1'b1;
        keys[7] = 1'b1;
        t = r + 12;
        n = r + 100;
        push(4'd4, t, t);
        push_repeats(4'd4, t, n);
        wait_until(r + 60);
        check("multi_held", {3'b000, key_held}, 4'd1);
        wait_until(n);
        keys[4] = 1'b0;
        keys[7] = 1'b0;
        wait_until(n + 12);
        check("multi_rel_held", {3'b000, key_held}, 4'd0);
        check("multi_rel_row", row_n, 4'b1011);

        // Release bounce returns to HOLD without a new pulse.
        wait_row(2, r);
        keys[9] = 1'b1;
        t = r + 12;
        push(4'd9, t, t);
        wait_until(t + 5);
        for (int i = 0; i < 3; i++) begin
            keys[9] = 1'b0;
            repeat (3) @(negedge clk);
            keys[9] = 1'b1;
            @(negedge clk);
            check("relb_held", {3'b000, key_held}, 4'd1);
        end
        n = cyc;
        keys[9] = 1'b0;
        wait_until(n + 8);
        check("relb_held_8", {3'b000, key_held}, 4'd1);
        wait_until(n + 12);
        check("relb_held_off", {3'b000, key_held}, 4'd0);
        check("relb_row3", row_n, 4'b0111);

        // Reset in PRESS_DEB at debounce count 5, key 0 kept pressed.
        wait_row(0, r);
        keys[0] = 1'b1;
        wait_until(r + 9);
        rst_n = 1'b0;
        #1;
        check("mid_rst_row_n", row_n, 4'b1110);
        check("mid_rst_value", key_value, 4'd0);
        check("mid_rst_valid", {3'b000, key_valid}, 4'd0);
        check("mid_rst_held", {3'b000, key_held}, 4'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        s0 = cyc;
        t = s0 + 12;
        n = t + 121;
        push(4'd0, t, t);
        push_repeats(4'd0, t, n);
        wait_until(t + 60);
        check("rst_key_held", {3'b000, key_held}, 4'd1);
        wait_until(n);
        keys[0] = 1'b0;
        wait_until(n + 20);

        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL pending: got %0d missing pulses, required 0",
                     exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
